// File: rtl/control_unit.sv
// control_unit: microcode sequencer for the 8-bit bus CPU.
//
// Drives the bus-register strobes every cycle from a fetch/execute step counter,
// the IR opcode and the latched flags. It halts on HLT until clear.
//
// Ports:
//   clk         system clock; all state updates on the rising edge
//   clear       synchronous active-high reset
//   opcode      IR[7:4]
//   carry_flag  latched carry flag
//   zero_flag   latched zero flag
//   ctrl        control word:
//                 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO,
//                 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI
//   step        current microstep, 0..4
//   halted      high once HLT has executed
module control_unit (
  input  logic        clk,
  input  logic        clear,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [15:0] CwNone   = 16'h0000;
  localparam logic [15:0] CwFetch0 = 16'h4004; // CO MI
  localparam logic [15:0] CwFetch1 = 16'h1408; // RO II CE
  localparam logic [15:0] CwOpAddr = 16'h4800; // IO MI
  localparam logic [15:0] CwLdA    = 16'h1200; // RO AI
  localparam logic [15:0] CwLdB    = 16'h1020; // RO BI
  localparam logic [15:0] CwAdd    = 16'h0281; // EO AI FI
  localparam logic [15:0] CwSub    = 16'h02C1; // EO AI SU FI
  localparam logic [15:0] CwSta    = 16'h2100; // AO RI
  localparam logic [15:0] CwLdi    = 16'h0A00; // IO AI
  localparam logic [15:0] CwJmp    = 16'h0802; // IO J
  localparam logic [15:0] CwOut    = 16'h0110; // AO OI
  localparam logic [15:0] CwHlt    = 16'h8000; // HLT

  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [1:0] {StFetch0, StFetch1, StExec, StHalted} state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] micro_word;
  logic [2:0]  last_step;

  // Microcode ROM: step x opcode x flags -> control word.
  always_comb begin
    micro_word = CwNone;
    case (step_q)
      3'd0: micro_word = CwFetch0;
      3'd1: micro_word = CwFetch1;
      3'd2: begin
        case (opcode)
          OpLda, OpAdd, OpSub, OpSta: micro_word = CwOpAddr;
          OpLdi:                      micro_word = CwLdi;
          OpJmp:                      micro_word = CwJmp;
          OpJc:                       micro_word = carry_flag ? CwJmp : CwNone;
          OpJz:                       micro_word = zero_flag ? CwJmp : CwNone;
          OpOut:                      micro_word = CwOut;
          OpHlt:                      micro_word = CwHlt;
          default:                    micro_word = CwNone;
        endcase
      end
      3'd3: begin
        case (opcode)
          OpLda:        micro_word = CwLdA;
          OpAdd, OpSub: micro_word = CwLdB;
          OpSta:        micro_word = CwSta;
          default:      micro_word = CwNone;
        endcase
      end
      3'd4: begin
        case (opcode)
          OpAdd:   micro_word = CwAdd;
          OpSub:   micro_word = CwSub;
          default: micro_word = CwNone;
        endcase
      end
      default: micro_word = CwNone;
    endcase
  end

  always_comb begin
    last_step = 3'd2;
    case (opcode)
      OpAdd, OpSub: last_step = 3'd4;
      OpLda, OpSta: last_step = 3'd3;
      default:      last_step = 3'd2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (state_q == StHalted) begin
      state_d = StHalted;
    end else if (step_q > 3'd4) begin
      // Unreachable step values recover straight to fetch.
      state_d = StFetch0;
      step_d  = 3'd0;
    end else begin
      unique case (state_q)
        StFetch0: begin
          state_d = StFetch1;
          step_d  = 3'd1;
        end
        StFetch1: begin
          state_d = StExec;
          step_d  = 3'd2;
        end
        StExec: begin
          if (micro_word[15]) begin
            state_d = StHalted;
          end else if (step_q == last_step) begin
            state_d = StFetch0;
            step_d  = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        default: begin
          state_d = StFetch0;
          step_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StFetch0;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // No bus driver may be enabled while clear is held; once halted the word is pinned to HLT.
  always_comb begin
    if (clear) begin
      ctrl = CwNone;
    end else if (state_q == StHalted) begin
      ctrl = CwHlt;
    end else begin
      ctrl = micro_word;
    end
  end

  assign step   = step_q;
  assign halted = (state_q == StHalted);

endmodule

// File: doc/control_unit.md
# control_unit

Microcode sequencer for the 8-bit bus CPU. It is the initiator side of the shared-bus register protocol: every cycle it drives the load/enable strobes that the bus registers (A, B, IR, MAR, RAM, PC, ALU, OUT, flags) respond to. It runs a fetch/execute step counter, decodes the IR opcode and the latched flags into a 16-bit control word, and halts on HLT.

## Interface
- No parameters. The microcode is fixed.
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  reset, synchronous, active-high.
- opcode  input  4  upper nibble of the instruction register (IR[7:4]).
- carry_flag  input  1  latched carry from the flags register.
- zero_flag  input  1  latched zero from the flags register.
- ctrl  output  16  control word. Bit assignments: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
- step  output  3  current microstep, 0–4.
- halted  output  1  high once HLT has executed.

## Operation
- Fetch steps are the same for every opcode:
  - Step 0: CO MI (0x4004).
  - Step 1: RO II CE (0x1408).
- Execute steps (step 2 onward). Any step not listed drives 0x0000.
  - 0x0 NOP: none.
  - 0x1 LDA: s2 IO MI (0x4800); s3 RO AI (0x1200).
  - 0x2 ADD: s2 0x4800; s3 RO BI (0x1020); s4 EO AI FI (0x0281).
  - 0x3 SUB: s2 0x4800; s3 0x1020; s4 EO AI SU FI (0x02C1).
  - 0x4 STA: s2 0x4800; s3 AO RI (0x2100).
  - 0x5 LDI: s2 IO AI (0x0A00).
  - 0x6 JMP: s2 IO J (0x0802).
  - 0x7 JC: s2 0x0802 if carry_flag, else 0x0000.
  - 0x8 JZ: s2 0x0802 if zero_flag, else 0x0000.
  - 0xE OUT: s2 AO OI (0x0110).
  - 0xF HLT: s2 HLT (0x8000).
  - 0x9–0xD: decode as NOP.
- Last step per opcode: ADD and SUB end at 4; LDA and STA end at 3; all other opcodes end at 2.
- States: FETCH0 → FETCH1 → EXEC(step 2..last) → FETCH0. HALTED is terminal until clear.
- Step update on each edge, with priority:
  1. clear → step=0, halted=0.
  2. halted → hold.
  3. step≥2 and ctrl[15] → halted=1, step held.
  4. step≥2 and step==last(opcode) → step=0.
  5. Otherwise step+1.
- Steps 0 and 1 always advance, whatever the opcode input. The IR is still loading during step 1.
- Step never exceeds 4, and the values 5–7 are unreachable. If one is reached anyway, ctrl=0 and the next edge sets step=0.

## Timing
- ctrl is combinational from the registered step, opcode and flags. It is stable for the whole cycle and sampled by bus registers on the next rising edge.
- The IR loads at the end of step 1. The opcode is valid from step 2.
- Flags are sampled combinationally during step 2. A flag change that lands in the same edge as FI has no effect until the next instruction.
- While clear is high, ctrl is forced to 0x0000, so no bus driver is enabled during reset.
- Reset values, on the first cycle after clear falls: step=0, halted=0, ctrl=0x4004.
- Instruction latency in cycles: NOP, LDI, JMP, JC, JZ, OUT = 3; LDA, STA = 4; ADD, SUB = 5.
- HLT:
  - The ctrl=0x8000 cycle is step 2. At that edge halted rises.
  - After that, step stays 2 and ctrl stays 0x8000 until clear.
- Clear asserted mid-instruction: step=0 at that edge, and fetch restarts after release.
- Clear asserted while halted: unhalts. halted=0 at that edge.

## Test plan
- Reset: hold clear 2 cycles → ctrl=0x0000 during clear. Release → ctrl 0x4004, then 0x1408, step 0→1.
- LDA with opcode=1 → ctrl sequence 0x4004, 0x1408, 0x4800, 0x1200, then 0x4004. Step returns to 0 after 3.
- SUB with opcode=3 → step 2, 3, 4 give 0x4800, 0x1020, 0x02C1, then wrap. Repeat with opcode=2 → step 4 gives 0x0281.
- JC with carry_flag=0 → step 2 gives 0x0000, then step 0. JC with carry_flag=1 → 0x0802. JZ gives the same results using zero_flag.
- HLT with opcode=F → at step 2, ctrl=0x8000 and halted=1 from the next edge. 10 further cycles: step=2, ctrl=0x8000. Assert clear → halted=0, step=0.
- Mid-instruction clear: opcode=2 with clear pulsed at step 3 → next cycle step=0. After release, ctrl=0x4004. Opcode 0xB → behaves as NOP (3 cycles).
